// File: rtl/logic_fu_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : logic_fu_scheduler_if                                  |
// | Brief   : RS request/operand bus and CDB result bus of logic FU  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface logic_fu_scheduler_if #(
  parameter int NUM_RS = 4,
  parameter int TAG_W  = 4
);
  logic [NUM_RS-1:0]       rs_req;
  logic [2*NUM_RS-1:0]     rs_op;
  logic [32*NUM_RS-1:0]    rs_a;
  logic [32*NUM_RS-1:0]    rs_b;
  logic [TAG_W*NUM_RS-1:0] rs_tag;
  logic [NUM_RS-1:0]       rs_gnt;
  logic                    cdb_req;
  logic                    cdb_gnt;
  logic [31:0]             cdb_data;
  logic [TAG_W-1:0]        cdb_tag;

  // master is the scheduler side; slave is the RS array plus CDB arbiter
  modport master (
    input  rs_req, rs_op, rs_a, rs_b, rs_tag, cdb_gnt,
    output rs_gnt, cdb_req, cdb_data, cdb_tag
  );
  modport slave (
    output rs_req, rs_op, rs_a, rs_b, rs_tag, cdb_gnt,
    input  rs_gnt, cdb_req, cdb_data, cdb_tag
  );
endinterface
`default_nettype wire

// File: rtl/logic_fu_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : logic_fu_scheduler                                     |
// | Brief   : Round-robin RS arbiter, bitwise logic unit, CDB sender |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module logic_fu_scheduler #(
  parameter int NUM_RS = 4,
  parameter int TAG_W  = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  flush_i,
  output logic                 busy_o,
  logic_fu_scheduler_if.master bus
);
  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CAPTURE   = 2'd1,
    S_BROADCAST = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   last_q;
  logic [1:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [NUM_RS-1:0]  rs_gnt_q;
  logic               cdb_req_q;
  logic [31:0]        cdb_data_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic               busy_q;

  logic [1:0]         op_arr  [NUM_RS];
  logic [31:0]        a_arr   [NUM_RS];
  logic [31:0]        b_arr   [NUM_RS];
  logic [TAG_W-1:0]   tag_arr [NUM_RS];

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;
  logic [31:0]        result;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_unpack
    assign op_arr[i]  = bus.rs_op[2*i +: 2];
    assign a_arr[i]   = bus.rs_a[32*i +: 32];
    assign b_arr[i]   = bus.rs_b[32*i +: 32];
    assign tag_arr[i] = bus.rs_tag[TAG_W*i +: TAG_W];
  end

  // Search starts one past the last winner and wraps modulo NUM_RS
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_RS; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_RS)) begin
        cand = cand - (IDX_W+1)'(NUM_RS);
      end
      if (!win_found && bus.rs_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   result = a_q & b_q;
      2'b01:   result = a_q | b_q;
      2'b10:   result = ~(a_q | b_q);
      default: result = a_q ^ b_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= IDX_W'(NUM_RS - 1);
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      rs_gnt_q   <= '0;
      cdb_req_q  <= 1'b0;
      cdb_data_q <= '0;
      cdb_tag_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      rs_gnt_q <= '0;
      // Flush squashes the op but leaves the last broadcast value visible
      if (flush_i) begin
        state_q   <= S_IDLE;
        cdb_req_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (win_found) begin
              op_q     <= op_arr[win_idx];
              a_q      <= a_arr[win_idx];
              b_q      <= b_arr[win_idx];
              tag_q    <= tag_arr[win_idx];
              last_q   <= win_idx;
              rs_gnt_q <= NUM_RS'(1) << win_idx;
              state_q  <= S_CAPTURE;
              busy_q   <= 1'b1;
            end
          end
          S_CAPTURE: begin
            cdb_data_q <= result;
            cdb_tag_q  <= tag_q;
            cdb_req_q  <= 1'b1;
            state_q    <= S_BROADCAST;
          end
          S_BROADCAST: begin
            if (bus.cdb_gnt) begin
              cdb_req_q <= 1'b0;
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
            end
          end
          default: begin
            cdb_req_q <= 1'b0;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rs_gnt   = rs_gnt_q;
  assign bus.cdb_req  = cdb_req_q;
  assign bus.cdb_data = cdb_data_q;
  assign bus.cdb_tag  = cdb_tag_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_fu_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_logic_fu_scheduler                                  |
// | Brief   : Directed + random bench with transaction-level model   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_logic_fu_scheduler;
  localparam int NUM_RS = 4;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;

  logic_fu_scheduler_if #(.NUM_RS(NUM_RS), .TAG_W(TAG_W)) bus ();

  logic_fu_scheduler #(.NUM_RS(NUM_RS), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .busy_o  (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [NUM_RS-1:0] req_v;
  logic [1:0]        op_v  [NUM_RS];
  logic [31:0]       a_v   [NUM_RS];
  logic [31:0]       b_v   [NUM_RS];
  logic [TAG_W-1:0]  tag_v [NUM_RS];

  int                m_last;
  int                m_win;
  logic [31:0]       exp_data;
  logic [TAG_W-1:0]  exp_tag;

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  function automatic int rr_pick(input logic [NUM_RS-1:0] mask, input int last);
    for (int k = 1; k <= NUM_RS; k++) begin
      if (mask[(last + k) % NUM_RS]) return (last + k) % NUM_RS;
    end
    return -1;
  endfunction

  function automatic logic [NUM_RS-1:0] onehot(input int i);
    logic [NUM_RS-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.rs_req = req_v;
    for (int i = 0; i < NUM_RS; i++) begin
      bus.rs_op[2*i +: 2]          = op_v[i];
      bus.rs_a[32*i +: 32]         = a_v[i];
      bus.rs_b[32*i +: 32]         = b_v[i];
      bus.rs_tag[TAG_W*i +: TAG_W] = tag_v[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue from IDLE and follow the op into BROADCAST
  task automatic start_txn(input logic [NUM_RS-1:0] req);
    req_v = req;
    drive();
    m_win = rr_pick(req, m_last);
    step();
    chk("rs_gnt", bus.rs_gnt, onehot(m_win));
    chk("busy_cap", busy, 1);
    m_last   = m_win;
    exp_data = ref_op(op_v[m_win], a_v[m_win], b_v[m_win]);
    exp_tag  = tag_v[m_win];
    req_v[m_win] = 1'b0;
    drive();
    step();
    chk("cdb_req", bus.cdb_req, 1);
    chk("cdb_data", bus.cdb_data, exp_data);
    chk("cdb_tag", bus.cdb_tag, exp_tag);
    chk("rs_gnt_pulse", bus.rs_gnt, 0);
  endtask

  task automatic finish_txn(input int stall);
    repeat (stall) begin
      step();
      chk("stall_req", bus.cdb_req, 1);
      chk("stall_data", bus.cdb_data, exp_data);
      chk("stall_tag", bus.cdb_tag, exp_tag);
    end
    bus.cdb_gnt = 1'b1;
    step();
    bus.cdb_gnt = 1'b0;
    chk("cdb_req_drop", bus.cdb_req, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.cdb_gnt = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      op_v[i] = 2'd0; a_v[i] = '0; b_v[i] = '0; tag_v[i] = TAG_W'(i);
    end
    req_v = '0;
    drive();
    m_last = NUM_RS - 1;
    repeat (2) step();
    chk("rst_gnt", bus.rs_gnt, 0);
    chk("rst_req", bus.cdb_req, 0);
    chk("rst_data", bus.cdb_data, 0);
    chk("rst_tag", bus.cdb_tag, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Four ops on RS1 with fixed operands
    a_v[1] = 32'hF0F0_00FF;
    b_v[1] = 32'h0FF0_0F0F;
    for (int op = 0; op < 4; op++) begin
      op_v[1]  = 2'(op);
      tag_v[1] = 4'(op + 9);
      start_txn(4'b0010);
      case (op)
        0: chk("t2_and", bus.cdb_data, 32'h00F0_000F);
        1: chk("t2_or",  bus.cdb_data, 32'hFFF0_0FFF);
        2: chk("t2_nor", bus.cdb_data, 32'h000F_F000);
        default: chk("t2_xor", bus.cdb_data, 32'hFF00_0FF0);
      endcase
      finish_txn(0);
    end

    // CDB stall then back-to-back issue
    start_txn(4'b0100);
    finish_txn(5);
    start_txn(4'b0001);
    finish_txn(1);

    // Wrap: RS3 wins, then 0101 goes to RS0 then RS2
    start_txn(4'b1000);
    finish_txn(0);
    start_txn(4'b0101);
    chk("t6_rs0", m_win, 0);
    finish_txn(0);
    start_txn(req_v);
    chk("t6_rs2", m_win, 2);
    finish_txn(0);

    // Fairness with all requesting and CDB always granting
    for (int i = 0; i < NUM_RS; i++) begin
      op_v[i] = 2'($urandom_range(0, 3)); a_v[i] = $urandom; b_v[i] = $urandom;
      tag_v[i] = 4'($urandom);
    end
    req_v = '1;
    drive();
    bus.cdb_gnt = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c % 3 == 1) begin
        m_win  = rr_pick(req_v, m_last);
        m_last = m_win;
        chk("t4_gnt", bus.rs_gnt, onehot(m_win));
      end else begin
        chk("t4_nognt", bus.rs_gnt, 0);
      end
      if (c % 3 == 2) begin
        chk("t4_data", bus.cdb_data, ref_op(op_v[m_win], a_v[m_win], b_v[m_win]));
        chk("t4_tag", bus.cdb_tag, tag_v[m_win]);
      end
    end
    bus.cdb_gnt = 1'b0;
    req_v = '0;
    drive();
    step();
    chk("t4_idle", busy, 0);

    // Flush beats CDB_GNT in BROADCAST
    start_txn(4'b0110);
    flush = 1'b1;
    bus.cdb_gnt = 1'b1;
    step();
    flush = 1'b0;
    bus.cdb_gnt = 1'b0;
    chk("t5_req", bus.cdb_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_data_kept", bus.cdb_data, exp_data);
    // Flush beats RS_REQ in IDLE; pointer unchanged afterwards
    req_v = 4'b0011;
    drive();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_nognt", bus.rs_gnt, 0);
    chk("t5_idle", busy, 0);
    start_txn(4'b0011);
    finish_txn(0);
    // Flush during CAPTURE: no broadcast follows
    req_v = 4'b1001;
    drive();
    m_win = rr_pick(req_v, m_last);
    step();
    chk("t5c_gnt", bus.rs_gnt, onehot(m_win));
    m_last = m_win;
    req_v = '0;
    drive();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5c_req", bus.cdb_req, 0);
    step();
    chk("t5c_req2", bus.cdb_req, 0);
    chk("t5c_busy", busy, 0);

    // Async reset mid-BROADCAST, then first grant to RS0
    start_txn(4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_req", bus.cdb_req, 0);
    chk("t1_busy", busy, 0);
    chk("t1_data", bus.cdb_data, 0);
    m_last = NUM_RS - 1;
    step();
    rst_n = 1'b1;
    start_txn(4'b1111);
    chk("t1_rs0", m_win, 0);
    finish_txn(0);

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NUM_RS; i++) begin
        op_v[i] = 2'($urandom_range(0, 3)); a_v[i] = $urandom; b_v[i] = $urandom;
        tag_v[i] = 4'($urandom);
      end
      start_txn(4'($urandom_range(1, 15)));
      finish_txn(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
